fetch2_bundle_queue: RTL and testbench

Decoupling queue between the Fetch2 stage and Decode. It captures complete fetch bundles (FETCH_WIDTH lane slots plus per-lane valid bits) produced from the Fetch1/Fetch2 pipeline register and presents them in order to Decode. It generates the `stall` that holds the Fetch1/Fetch2 register and the upstream fetch stages whenever the queue is full. All state is cleared on reset or on a front-end flush.

---
 rtl/fetch2_bundle_queue.sv | 112 +++++++++++
 tb/tb_fetch2_bundle_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch2_bundle_queue.sv
// fetch2_bundle_queue: in-order decoupling queue of fetch bundles between Fetch2 and Decode.
// Latency: 1 cycle from the push edge to the head outputs; no empty bypass.
// Backpressure: stall_o = full, from registered state only; a push is refused when full, even with a pop that cycle.

// fifo: generic circular buffer with separate occupancy count and synchronous clear.
// Latency: an entry written at edge N is at head_dat in cycle N+1.
// Backpressure: none internally; the caller gates push_vld/pop_rdy with full/empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign head_dat = mem[head];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_vld) tail <= tail + 1'b1;
            if (pop_rdy)  head <= head + 1'b1;
            if (push_vld && !pop_rdy)      count <= count + 1'b1;
            else if (!push_vld && pop_rdy) count <= count - 1'b1;
        end
    end

    // Storage is not reset: stale entries are never visible because outputs are gated by empty.
    always_ff @(posedge clk) begin
        if (push_vld && !reset && !clr) mem[tail] <= push_dat;
    end
endmodule

module fetch2_bundle_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int PKT_WIDTH   = 64,
    parameter int DEPTH       = 4,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic                           bundleValid_i,
    input  logic [FETCH_WIDTH-1:0]         laneValid_i,
    input  logic [FETCH_WIDTH*PKT_WIDTH-1:0] data_i,
    input  logic                           decReady_i,
    output logic                           stall_o,
    output logic                           bundleValid_o,
    output logic [FETCH_WIDTH-1:0]         laneValid_o,
    output logic [FETCH_WIDTH*PKT_WIDTH-1:0] data_o,
    output logic [CW-1:0]                  count_o
);
    typedef struct packed {
        logic [FETCH_WIDTH-1:0]           lane_vld;
        logic [FETCH_WIDTH*PKT_WIDTH-1:0] dat;
    } bundle_t;

    bundle_t in_bundle;
    bundle_t head_bundle;
    logic    full;
    logic    empty;
    logic    push_en;
    logic    pop_en;

    assign in_bundle.lane_vld = laneValid_i;
    assign in_bundle.dat      = data_i;

    // All-lanes-invalid bundles carry nothing for Decode and are dropped without a stall.
    assign push_en = bundleValid_i & (|laneValid_i) & ~full & ~flush_i;
    assign pop_en  = ~empty & decReady_i & ~flush_i;

    fifo #(
        .WIDTH ($bits(bundle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush_i),
        .push_vld (push_en),
        .push_dat (in_bundle),
        .pop_rdy  (pop_en),
        .head_dat (head_bundle),
        .full     (full),
        .empty    (empty),
        .count    (count_o)
    );

    assign stall_o       = full;
    assign bundleValid_o = ~empty;
    assign laneValid_o   = empty ? '0 : head_bundle.lane_vld;
    assign data_o        = empty ? '0 : head_bundle.dat;
endmodule

// File: tb/tb_fetch2_bundle_queue.sv
// Directed bench for fetch2_bundle_queue: fill/stall, streaming, empty-lane drop, flush and reset.
module tb_fetch2_bundle_queue;
    logic         clk = 1'b0;
    logic         reset;
    logic         flush_i;
    logic         bundleValid_i;
    logic [3:0]   laneValid_i;
    logic [255:0] data_i;
    logic         decReady_i;
    logic         stall_o;
    logic         bundleValid_o;
    logic [3:0]   laneValid_o;
    logic [255:0] data_o;
    logic [2:0]   count_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch2_bundle_queue dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .bundleValid_i (bundleValid_i),
        .laneValid_i   (laneValid_i),
        .data_i        (data_i),
        .decReady_i    (decReady_i),
        .stall_o       (stall_o),
        .bundleValid_o (bundleValid_o),
        .laneValid_o   (laneValid_o),
        .data_o        (data_o),
        .count_o       (count_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane i of bundle t holds {t, i}, so order and lane placement are both visible.
    function automatic logic [255:0] mk(input int t);
        logic [255:0] r;
        for (int i = 0; i < 4; i++) r[i*64 +: 64] = (64'(t) << 8) | 64'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int t, input logic [3:0] lv);
        bundleValid_i = 1'b1;
        laneValid_i   = lv;
        data_i        = mk(t);
    endtask

    task automatic idle_in();
        bundleValid_i = 1'b0;
        laneValid_i   = 4'b0;
        data_i        = '0;
    endtask

    initial begin
        logic [255:0] d0;
        reset = 1'b1; flush_i = 1'b0; decReady_i = 1'b0;
        idle_in();
        step(); step();
        chk("rst_stall", 256'(stall_o), 256'(0));
        chk("rst_bvld",  256'(bundleValid_o), 256'(0));
        chk("rst_lane",  256'(laneValid_o), 256'(0));
        chk("rst_data",  data_o, 256'(0));
        chk("rst_cnt",   256'(count_o), 256'(0));
        reset = 1'b0;

        // First bundle: 1-cycle latency to the head.
        d0 = {64'h44, 64'h33, 64'h22, 64'h11};
        bundleValid_i = 1'b1; laneValid_i = 4'b1111; data_i = d0;
        step();
        idle_in();
        chk("t1_bvld",  256'(bundleValid_o), 256'(1));
        chk("t1_lane",  256'(laneValid_o), 256'(4'b1111));
        chk("t1_data",  data_o, d0);
        chk("t1_cnt",   256'(count_o), 256'(1));
        chk("t1_stall", 256'(stall_o), 256'(0));

        // Fill to DEPTH, then hold a 5th bundle against the stall.
        for (int t = 1; t <= 3; t++) begin
            offer(t, 4'b1111);
            step();
        end
        chk("full_cnt",   256'(count_o), 256'(4));
        chk("full_stall", 256'(stall_o), 256'(1));
        offer(4, 4'b0011);
        step();
        chk("held_cnt",  256'(count_o), 256'(4));
        chk("held_head", data_o, d0);
        decReady_i = 1'b1;
        step();
        decReady_i = 1'b0;
        chk("popfull_cnt",   256'(count_o), 256'(3));
        chk("popfull_stall", 256'(stall_o), 256'(0));
        chk("popfull_head",  data_o, mk(1));
        step();
        idle_in();
        chk("late_push_cnt",   256'(count_o), 256'(4));
        chk("late_push_stall", 256'(stall_o), 256'(1));
        decReady_i = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            chk($sformatf("drain_dat%0d", t), data_o, mk(t));
            chk($sformatf("drain_lane%0d", t), 256'(laneValid_o), 256'((t == 4) ? 4'b0011 : 4'b1111));
            step();
        end
        chk("drained_cnt",  256'(count_o), 256'(0));
        chk("drained_bvld", 256'(bundleValid_o), 256'(0));
        chk("drained_data", data_o, 256'(0));

        // Streaming: one bundle per cycle, occupancy pinned at 1, pointers wrap.
        for (int k = 0; k < 10; k++) begin
            offer(100 + k, 4'b1111);
            step();
            chk($sformatf("stream_dat%0d", k), data_o, mk(100 + k));
            chk($sformatf("stream_cnt%0d", k), 256'(count_o), 256'(1));
        end
        idle_in();
        step();
        chk("stream_end_cnt", 256'(count_o), 256'(0));
        decReady_i = 1'b0;

        // All-lanes-invalid bundle is dropped, both empty and non-empty.
        offer(150, 4'b0000);
        step();
        chk("drop_empty_cnt",  256'(count_o), 256'(0));
        chk("drop_empty_bvld", 256'(bundleValid_o), 256'(0));
        offer(151, 4'b0100);
        step();
        offer(152, 4'b0000);
        step();
        chk("drop_cnt",  256'(count_o), 256'(1));
        chk("drop_head", data_o, mk(151));
        chk("drop_lane", 256'(laneValid_o), 256'(4'b0100));
        idle_in();
        decReady_i = 1'b1;
        step();
        decReady_i = 1'b0;
        chk("drop_pop_cnt", 256'(count_o), 256'(0));

        // Flush with push and pop offered in the same cycle.
        for (int t = 200; t < 203; t++) begin
            offer(t, 4'b1010);
            step();
        end
        chk("preflush_cnt", 256'(count_o), 256'(3));
        flush_i = 1'b1; decReady_i = 1'b1;
        offer(203, 4'b1111);
        step();
        flush_i = 1'b0; decReady_i = 1'b0;
        idle_in();
        chk("flush_cnt",  256'(count_o), 256'(0));
        chk("flush_bvld", 256'(bundleValid_o), 256'(0));
        chk("flush_data", data_o, 256'(0));
        chk("flush_lane", 256'(laneValid_o), 256'(0));
        offer(204, 4'b1111);
        step();
        idle_in();
        chk("postflush_cnt", 256'(count_o), 256'(1));
        chk("postflush_dat", data_o, mk(204));
        decReady_i = 1'b1;
        step();
        decReady_i = 1'b0;
        chk("postflush_pop_cnt",  256'(count_o), 256'(0));
        chk("postflush_pop_bvld", 256'(bundleValid_o), 256'(0));

        // Reset while full.
        for (int t = 300; t < 304; t++) begin
            offer(t, 4'b1111);
            step();
        end
        chk("prerst_stall", 256'(stall_o), 256'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_in();
        chk("fullrst_stall", 256'(stall_o), 256'(0));
        chk("fullrst_bvld",  256'(bundleValid_o), 256'(0));
        chk("fullrst_lane",  256'(laneValid_o), 256'(0));
        chk("fullrst_data",  data_o, 256'(0));
        chk("fullrst_cnt",   256'(count_o), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
